// File: rtl/decode_pkg.sv
// Shared opcode constants, format codes and decoded-field bundle for the
// instruction field decoder.
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } dec_fields_t;

    // Non-11 low bits mark a compressed/unsupported encoding; treat as illegal.
    function automatic fmt_e classify(input logic [31:0] instr);
        if (instr[1:0] != 2'b11) return FMT_ILL;
        case (instr[6:0])
            OP_REG:                                         return FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:  return FMT_I;
            OP_STORE:                                       return FMT_S;
            OP_BRANCH:                                      return FMT_B;
            OP_LUI, OP_AUIPC:                               return FMT_U;
            OP_JAL:                                         return FMT_J;
            default:                                        return FMT_ILL;
        endcase
    endfunction

endpackage

// File: rtl/inst_field_decoder_imm_gen.sv
// Immediate generator: reassembles the format-specific immediate bits and
// sign-extends from instr[31] to XLEN. R and illegal formats yield zero.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = XLEN'($signed(instr[31:20]));
            FMT_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/inst_field_decoder.sv
// RV base-format instruction field decoder with a valid/ready output stage;
// SKID selects a two-entry skid (registered in_ready) or a single register.
module inst_field_decoder
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    fmt_e            d_fmt;
    dec_fields_t     d_f, o_f;
    logic [XLEN-1:0] d_imm, o_imm, o_pc;
    logic            in_xfer, out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Fields a format does not carry are forced to zero so downstream never
    // sees stray register indices.
    always_comb begin
        d_fmt     = classify(in_instr);
        d_f       = '0;
        d_f.opcode  = in_instr[6:0];
        d_f.fmt     = d_fmt;
        d_f.illegal = (d_fmt == FMT_ILL);
        if (d_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) d_f.rd = in_instr[11:7];
        if (d_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) begin
            d_f.rs1    = in_instr[19:15];
            d_f.funct3 = in_instr[14:12];
        end
        if (d_fmt inside {FMT_R, FMT_S, FMT_B}) d_f.rs2 = in_instr[24:20];
        if (d_fmt == FMT_R) d_f.funct7 = in_instr[31:25];
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .fmt   (d_fmt),
        .imm   (d_imm)
    );

    if (SKID != 0) begin : g_skid
        occ_e            state;
        dec_fields_t     s_f;
        logic [XLEN-1:0] s_imm, s_pc;

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= OCC_EMPTY;
                o_f   <= '0;
                o_imm <= '0;
                o_pc  <= '0;
                s_f   <= '0;
                s_imm <= '0;
                s_pc  <= '0;
            end else begin
                case (state)
                    OCC_EMPTY: if (in_xfer) begin
                        {o_f, o_imm, o_pc} <= {d_f, d_imm, in_pc};
                        state <= OCC_ONE;
                    end
                    OCC_ONE: if (in_xfer && out_xfer) begin
                        {o_f, o_imm, o_pc} <= {d_f, d_imm, in_pc};
                    end else if (in_xfer) begin
                        {s_f, s_imm, s_pc} <= {d_f, d_imm, in_pc};
                        state <= OCC_FULL;
                    end else if (out_xfer) begin
                        state <= OCC_EMPTY;
                    end
                    OCC_FULL: if (out_xfer) begin
                        {o_f, o_imm, o_pc} <= {s_f, s_imm, s_pc};
                        state <= OCC_ONE;
                    end
                    default: state <= OCC_EMPTY;
                endcase
            end
        end

        // Both handshake outputs come straight from the state register.
        assign out_valid = (state != OCC_EMPTY);
        assign in_ready  = (state != OCC_FULL);
    end else begin : g_reg
        logic vld;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld   <= 1'b0;
                o_f   <= '0;
                o_imm <= '0;
                o_pc  <= '0;
            end else if (in_xfer) begin
                vld <= 1'b1;
                {o_f, o_imm, o_pc} <= {d_f, d_imm, in_pc};
            end else if (out_xfer) begin
                vld <= 1'b0;
            end
        end

        assign out_valid = vld;
        assign in_ready  = !vld || out_ready;
    end

    assign out_pc      = o_pc;
    assign out_opcode  = o_f.opcode;
    assign out_rd      = o_f.rd;
    assign out_rs1     = o_f.rs1;
    assign out_rs2     = o_f.rs2;
    assign out_funct3  = o_f.funct3;
    assign out_funct7  = o_f.funct7;
    assign out_fmt     = o_f.fmt;
    assign out_imm     = o_imm;
    assign out_illegal = o_f.illegal;

endmodule

// File: doc/inst_field_decoder.md
Name: inst_field_decoder

Overview:
Parametrised instruction field splitter for all six RV base formats (R/I/S/B/U/J). It replaces the single-format combinational splitters. Adds format classification, XLEN sign-extended immediate generation, illegal-opcode flagging and a valid/ready registered output stage with an optional skid buffer. It sits between fetch and the decode/rename stage; the PC travels alongside the instruction.

Parameters:
XLEN, 32, datapath width for pc and immediate; legal values are 32 and 64.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept this cycle
in_instr  in  32  raw instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts
out_pc  out  XLEN  pc of the decoded entry
out_opcode  out  7  instr[6:0]
out_rd  out  5  instr[11:7]; forced 0 for S/B
out_rs1  out  5  instr[19:15]; forced 0 for U/J
out_rs2  out  5  instr[24:20]; forced 0 for I/U/J
out_funct3  out  3  instr[14:12]; forced 0 for U/J
out_funct7  out  7  instr[31:25]; forced 0 unless R
out_fmt  out  3  fmt_e code
out_imm  out  XLEN  sign-extended immediate; 0 for R and illegal
out_illegal  out  1  unknown opcode, or instr[1:0] != 2'b11

Behaviour:
- Reset (synchronous, clk edge with rst=1): out_valid=0, all out_* data=0, skid empty, in_ready=1 on the cycle after reset. rst overrides any handshake in the same cycle. Entries in flight are dropped.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Latency: 1 cycle from input transfer to out_valid.
- Output hold: outputs stay stable while out_valid && !out_ready.
- Format map:
  - 0110011 -> R
  - 0010011 / 0000011 / 1100111 / 1110011 / 0001111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111 / 0010111 -> U
  - 1101111 -> J
  - anything else -> ILL (out_illegal=1, out_imm=0, register fields 0)
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - The output register loads on input transfer.
  - out_valid clears on output transfer with no simultaneous input.
- SKID=1, state machine over occupancy:
  - EMPTY: out_valid=0. Input transfer -> ONE.
  - ONE: out_valid=1.
    - Input and output transfer together -> new entry to output, stay ONE.
    - Input only -> entry to skid, go FULL.
    - Output only -> EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - Output transfer -> skid moves to output, go ONE.
  - in_ready = (state != FULL), driven straight from the state register with no combinational path from out_ready.
  - Decoding happens before the skid, so the skid holds decoded fields.
- Throughput: sustained 1/cycle when out_ready=1, in both modes.
- XLEN=64: U immediate bits [63:32] replicate instr[31]. pc passes through unmodified.
- No wrap or overflow hazard: in_valid while in_ready=0 is simply not consumed.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM, OP_FENCE);
  - typedef enum logic[2:0] fmt_e {FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_ILL=7};
  - packed struct dec_fields_t bundling the decoded outputs.
- One combinational sub-module, imm_gen (instr, fmt -> imm[XLEN-1:0]). The top level holds classification, the pipeline register, the skid and the handshake.

Test Plan:
- LUI x5,0x12345 (0x123452B7), out_ready=1 -> next cycle out_valid=1, opcode=0x37, rd=5, fmt=U, imm=0x12345000, rs1=rs2=0.
- AUIPC x1,0xFFFFF (0xFFFFF097), run with XLEN=32 and XLEN=64 -> imm=0xFFFFF000 and 0xFFFFFFFFFFFFF000 respectively, rd=1, fmt=U.
- beq x1,x2,-4 (0xFE208EE3) -> fmt=B, rs1=1, rs2=2, rd=0, funct3=0, imm=0xFFFFFFFC.
- Backpressure, SKID=1: 3 back-to-back instructions with out_ready=0 -> first two accepted, in_ready=0 after the second, outputs stable. Raise out_ready -> all three delivered in order on consecutive cycles, none lost or duplicated.
- Word 0x00000000 -> out_illegal=1, fmt=7, imm=0. Word 0x00000013 (addi x0,x0,0) -> fmt=I, illegal=0.
- rst asserted while FULL and in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale entry emitted after release.
